// File: rtl/signed_extrema_tracker_pkg.sv
// Shared definitions for signed_extrema_tracker: FSM state encoding and the
// window count width helper used by the interface and the top.
package signed_extrema_tracker_pkg;

    typedef enum logic [1:0] {
        FIRST = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic [1:0] ST_FIRST = FIRST;
    localparam logic [1:0] ST_ACCUM = ACCUM;
    localparam logic [1:0] ST_DONE  = DONE;

    // Bits needed to hold window positions 0..window-1 (at least one bit).
    function automatic int cnt_width(input int window);
        int w;
        int v;
        w = 0;
        v = window - 1;
        while (v > 0) begin
            w = w + 1;
            v = v >> 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/signed_extrema_tracker_if.sv
// Sample/result handshake bundle for signed_extrema_tracker.
// The MIN_IDX/MAX_IDX signals exist only when SIGNED_EXTREMA_INDEX_EN is defined.
interface signed_extrema_tracker_if #(
    parameter int WIDTH  = 4,
    parameter int WINDOW = 8
);
    import signed_extrema_tracker_pkg::*;

    logic [WIDTH-1:0] I;
    logic             IN_VALID;
    logic             IN_READY;
    logic [WIDTH-1:0] MIN;
    logic [WIDTH-1:0] MAX;
    logic             OUT_VALID;
    logic             OUT_READY;
`ifdef SIGNED_EXTREMA_INDEX_EN
    localparam int CW = cnt_width(WINDOW);
    logic [CW-1:0]    MIN_IDX;
    logic [CW-1:0]    MAX_IDX;
`endif

    modport master (
        output I,
        output IN_VALID,
        input  IN_READY,
        input  MIN,
        input  MAX,
        input  OUT_VALID,
        output OUT_READY
`ifdef SIGNED_EXTREMA_INDEX_EN
        ,
        input  MIN_IDX,
        input  MAX_IDX
`endif
    );

    modport slave (
        input  I,
        input  IN_VALID,
        output IN_READY,
        output MIN,
        output MAX,
        output OUT_VALID,
        input  OUT_READY
`ifdef SIGNED_EXTREMA_INDEX_EN
        ,
        output MIN_IDX,
        output MAX_IDX
`endif
    );

endinterface

// File: rtl/signed_extrema_tracker_cmp.sv
// Signed less-than: LT = msb(A - B) XOR overflow, valid across the full
// two's-complement range including the most-negative versus most-positive pair.
module signed_slt_cmp #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             LT
);

    logic [WIDTH-1:0] b_inv;
    logic [WIDTH-1:0] carry;
    logic             d_msb;
    logic             ovf;

    assign b_inv    = ~B;
    assign carry[0] = 1'b1;

    // Only the difference sign is needed, so the A + ~B + 1 chain is built from
    // carries alone and the sign bit is formed from the last carry.
    for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_carry
        assign carry[gi+1] = (A[gi] & b_inv[gi]) | ((A[gi] ^ b_inv[gi]) & carry[gi]);
    end

    assign d_msb = A[WIDTH-1] ^ b_inv[WIDTH-1] ^ carry[WIDTH-1];
    assign ovf   = (A[WIDTH-1] != B[WIDTH-1]) && (d_msb != A[WIDTH-1]);
    assign LT    = d_msb ^ ovf;

endmodule

// File: rtl/signed_extrema_tracker.sv
// Windowed signed min/max tracker over a valid/ready stream.
// Optional MIN_IDX/MAX_IDX outputs are enabled by defining SIGNED_EXTREMA_INDEX_EN.
module signed_extrema_tracker
    import signed_extrema_tracker_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int WINDOW = 8
) (
    input  logic                    CLK,
    input  logic                    RESETN,
    signed_extrema_tracker_if.slave bus
);

    localparam int CW = cnt_width(WINDOW);
    localparam logic [CW-1:0] CNT_LAST = CW'(WINDOW - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [1:0]       state_reg, state_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [WIDTH-1:0] min_reg, min_next;
    logic [WIDTH-1:0] max_reg, max_next;
    logic             out_valid_reg, out_valid_next;

    logic             in_ready;
    logic             accept;
    logic             xfer;
    logic             lt_min;
    logic             lt_max;

    // Comparator 0 asks "I < MIN", comparator 1 asks "MAX < I".
    logic [WIDTH-1:0] cmp_a [2];
    logic [WIDTH-1:0] cmp_b [2];
    logic [1:0]       cmp_lt;

    assign cmp_a[0] = bus.I;
    assign cmp_b[0] = min_reg;
    assign cmp_a[1] = max_reg;
    assign cmp_b[1] = bus.I;

    for (genvar gi = 0; gi < 2; gi++) begin : g_cmp
        signed_slt_cmp #(.WIDTH(WIDTH)) u_cmp (
            .A  (cmp_a[gi]),
            .B  (cmp_b[gi]),
            .LT (cmp_lt[gi])
        );
    end

    assign lt_min = cmp_lt[0];
    assign lt_max = cmp_lt[1];

    // IN_READY is a pure decode of the state register.
    assign in_ready = (state_reg != ST_DONE);
    assign accept   = bus.IN_VALID && in_ready;
    assign xfer     = out_valid_reg && bus.OUT_READY;

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        min_next       = min_reg;
        max_next       = max_reg;
        out_valid_next = out_valid_reg;
        case (state_reg)
            ST_FIRST: begin
                if (accept) begin
                    min_next   = bus.I;
                    max_next   = bus.I;
                    cnt_next   = CNT_ONE;
                    state_next = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (accept) begin
                    if (lt_min) begin
                        min_next = bus.I;
                    end
                    if (lt_max) begin
                        max_next = bus.I;
                    end
                    // The count may wrap on the final sample; it is unused in DONE.
                    cnt_next = cnt_reg + CNT_ONE;
                    if (cnt_reg == CNT_LAST) begin
                        state_next     = ST_DONE;
                        out_valid_next = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (xfer) begin
                    state_next     = ST_FIRST;
                    out_valid_next = 1'b0;
                    cnt_next       = '0;
                end
            end
            default: begin
                state_next     = ST_FIRST;
                out_valid_next = 1'b0;
                cnt_next       = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_reg     <= ST_FIRST;
            cnt_reg       <= '0;
            min_reg       <= '0;
            max_reg       <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            min_reg       <= min_next;
            max_reg       <= max_next;
            out_valid_reg <= out_valid_next;
        end
    end

    assign bus.IN_READY  = in_ready;
    assign bus.MIN       = min_reg;
    assign bus.MAX       = max_reg;
    assign bus.OUT_VALID = out_valid_reg;

`ifdef SIGNED_EXTREMA_INDEX_EN
    logic [CW-1:0] min_idx_reg, min_idx_next;
    logic [CW-1:0] max_idx_reg, max_idx_next;

    // Each index records the window position of the sample that last set it.
    always_comb begin
        min_idx_next = min_idx_reg;
        max_idx_next = max_idx_reg;
        if (accept && (state_reg == ST_FIRST)) begin
            min_idx_next = '0;
            max_idx_next = '0;
        end else if (accept && (state_reg == ST_ACCUM)) begin
            if (lt_min) begin
                min_idx_next = cnt_reg;
            end
            if (lt_max) begin
                max_idx_next = cnt_reg;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            min_idx_reg <= '0;
            max_idx_reg <= '0;
        end else begin
            min_idx_reg <= min_idx_next;
            max_idx_reg <= max_idx_next;
        end
    end

    assign bus.MIN_IDX = min_idx_reg;
    assign bus.MAX_IDX = max_idx_reg;
`endif

endmodule

// File: tb/tb_signed_extrema_tracker.sv
// Scoreboard bench for signed_extrema_tracker (WIDTH=4, WINDOW=4) plus an
// exhaustive check of signed_slt_cmp; index checks follow SIGNED_EXTREMA_INDEX_EN.
module tb_signed_extrema_tracker;

    localparam int WIDTH  = 4;
    localparam int WINDOW = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    signed_extrema_tracker_if #(.WIDTH(WIDTH), .WINDOW(WINDOW)) bus ();

    signed_extrema_tracker #(.WIDTH(WIDTH), .WINDOW(WINDOW)) dut (
        .CLK    (clk),
        .RESETN (rst_n),
        .bus    (bus)
    );

    logic [3:0] ca;
    logic [3:0] cb;
    logic       clt;

    signed_slt_cmp #(.WIDTH(4)) u_ref_cmp (
        .A  (ca),
        .B  (cb),
        .LT (clt)
    );

    typedef struct {
        string      name;
        logic [3:0] mn;
        logic [3:0] mx;
        logic [1:0] mi;
        logic [1:0] xi;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: one result line per output transfer, compared against the queue head.
    always begin : monitor
        exp_t e;
        @(negedge clk);
        #1;
        if (rst_n && bus.OUT_VALID && bus.OUT_READY) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_result: got MIN=%0h MAX=%0h, expected no output",
                         bus.MIN, bus.MAX);
            end else begin
                e = exp_q.pop_front();
                $display("[TB] result %s: MIN=%0h MAX=%0h", e.name, bus.MIN, bus.MAX);
                check({e.name, "_min"}, int'(bus.MIN), int'(e.mn));
                check({e.name, "_max"}, int'(bus.MAX), int'(e.mx));
`ifdef SIGNED_EXTREMA_INDEX_EN
                check({e.name, "_min_idx"}, int'(bus.MIN_IDX), int'(e.mi));
                check({e.name, "_max_idx"}, int'(bus.MAX_IDX), int'(e.xi));
`endif
            end
        end
    end

    // Present one sample from a negedge and return at the negedge after it is taken.
    task automatic send(input logic [3:0] v);
        int guard;
        guard = 0;
        bus.I        = v;
        bus.IN_VALID = 1'b1;
        while ((bus.IN_READY !== 1'b1) && (guard < 50)) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: got IN_READY=%b for 50 cycles, expected 1", bus.IN_READY);
        end
        @(negedge clk);
        bus.IN_VALID = 1'b0;
    endtask

    // samples: s0 in [15:12] .. s3 in [3:0]
    task automatic run_window(input string name, input logic [15:0] samples,
                              input logic [3:0] mn, input logic [3:0] mx,
                              input logic [1:0] mi, input logic [1:0] xi,
                              input int max_gap);
        exp_t e;
        logic [3:0] s;
        e.name = name;
        e.mn   = mn;
        e.mx   = mx;
        e.mi   = mi;
        e.xi   = xi;
        exp_q.push_back(e);
        for (int k = 0; k < 4; k++) begin
            if (max_gap > 0) begin
                repeat ($urandom_range(max_gap, 0)) @(negedge clk);
            end
            if (k == 3) begin
                check({name, "_ov_before_last"}, int'(bus.OUT_VALID), 0);
            end
            s = samples[15 - 4 * k -: 4];
            send(s);
        end
        check({name, "_ov_after_last"}, int'(bus.OUT_VALID), 1);
        check({name, "_ir_in_done"}, int'(bus.IN_READY), 0);
        if (bus.OUT_READY === 1'b1) begin
            @(negedge clk);
            check({name, "_ov_one_cycle"}, int'(bus.OUT_VALID), 0);
            check({name, "_ir_after_xfer"}, int'(bus.IN_READY), 1);
        end
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got no completion by 100000 time units, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [7:0] ab;
        bus.I         = '0;
        bus.IN_VALID  = 1'b0;
        bus.OUT_READY = 1'b1;
        ca            = '0;
        cb            = '0;

        // Exhaustive comparator check against the language's signed compare.
        for (int i = 0; i < 256; i++) begin
            ab = 8'(i);
            ca = ab[7:4];
            cb = ab[3:0];
            #1;
            check("slt_cmp", int'(clt), int'($signed(ca) < $signed(cb)));
        end

        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_out_valid", int'(bus.OUT_VALID), 0);
        check("reset_in_ready", int'(bus.IN_READY), 1);
        check("reset_min", int'(bus.MIN), 0);
        check("reset_max", int'(bus.MAX), 0);
`ifdef SIGNED_EXTREMA_INDEX_EN
        check("reset_min_idx", int'(bus.MIN_IDX), 0);
        check("reset_max_idx", int'(bus.MAX_IDX), 0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] window basic 3,-2,7,-8");
        run_window("basic", 16'h3E78, 4'h8, 4'h7, 2'd3, 2'd2, 0);

        $display("[TB] window overflow 7,-8,7,-8");
        run_window("ovf", 16'h7878, 4'h8, 4'h7, 2'd1, 2'd0, 0);

        $display("[TB] window ties 2,5,2,5");
        run_window("ties", 16'h2525, 4'h2, 4'h5, 2'd0, 2'd1, 0);

        $display("[TB] window backpressure 1,-3,4,0");
        bus.OUT_READY = 1'b0;
        run_window("bp", 16'h1D40, 4'hD, 4'h4, 2'd1, 2'd2, 0);
        bus.I        = 4'h6;
        bus.IN_VALID = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_hold_ov", int'(bus.OUT_VALID), 1);
            check("bp_hold_min", int'(bus.MIN), 'hD);
            check("bp_hold_max", int'(bus.MAX), 'h4);
            check("bp_hold_ir", int'(bus.IN_READY), 0);
        end
        bus.OUT_READY = 1'b1;
        @(negedge clk);
        check("bp_release_ov", int'(bus.OUT_VALID), 0);
        check("bp_release_ir", int'(bus.IN_READY), 1);

        $display("[TB] window after backpressure 6,1,2,3");
        run_window("after_bp", 16'h6123, 4'h1, 4'h6, 2'd1, 2'd0, 0);

        $display("[TB] reset mid-window after 5,-5");
        send(4'h5);
        send(4'hB);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", int'(bus.OUT_VALID), 0);
        check("midrst_in_ready", int'(bus.IN_READY), 1);
        check("midrst_min", int'(bus.MIN), 0);
        check("midrst_max", int'(bus.MAX), 0);
        repeat (2) @(negedge clk);
        check("midrst_out_valid_held", int'(bus.OUT_VALID), 0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] window ones after reset 1,1,1,1");
        run_window("ones", 16'h1111, 4'h1, 4'h1, 2'd0, 2'd0, 0);

        $display("[TB] window with gaps -4,0,6,-1");
        run_window("gaps", 16'hC06F, 4'hC, 4'h6, 2'd0, 2'd2, 3);

        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
